// File: rtl/ibex_obi_mem_pkg.sv
// Shared types and helpers for the OBI memory responder.
package ibex_obi_mem_pkg;

  localparam int unsigned ObiDataWidth = 32;

  // 16-bit maximal-length Galois LFSR (x^16 + x^14 + x^13 + x^11 + 1), right-shifting form
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  // Default response shape for a 32-bit port; wider builds pass their own struct to the pipe
  typedef struct packed {
    logic                    valid;
    logic [ObiDataWidth-1:0] rdata;
    logic                    err;
  } resp_t;

  function automatic logic addr_decode(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input logic [63:0] depth_words,
                                       input int unsigned off_bits);
    return (addr >= base) && (((addr - base) >> off_bits) < depth_words);
  endfunction

endpackage

// File: rtl/ibex_obi_mem_resp_pipe.sv
// Fixed-depth response shift register; a synchronous clear drops everything in flight.
module ibex_obi_mem_resp_pipe
  import ibex_obi_mem_pkg::*;
#(
  parameter int  Depth   = 1,
  parameter type entry_t = resp_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  entry_t resp_d,
  output entry_t resp_q
);

  entry_t stage_q [1:Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 1; i <= Depth; i++) stage_q[i] <= '0;
    end else begin
      stage_q[1] <= resp_d;
      for (int i = 2; i <= Depth; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign resp_q = stage_q[Depth];

endmodule

// File: rtl/ibex_obi_mem_responder.sv
// Cycle-accurate OBI memory responder: bounded outstanding, in-order fixed-latency answers.
// Define IBEX_OBI_MEM_RANDOM_STALL_EN to add LFSR-driven grant stalls on top of StallPeriod.
module ibex_obi_mem_responder
  import ibex_obi_mem_pkg::*;
#(
  parameter int unsigned          AddrWidth      = 32,
  parameter int unsigned          DataWidth      = 32,
  parameter int unsigned          MemDepthWords  = 4096,
  parameter logic [AddrWidth-1:0] BaseAddr       = AddrWidth'(32'h0001_0000),
  parameter int unsigned          RespLatency    = 1,
  parameter int unsigned          MaxOutstanding = 2,
  parameter int unsigned          StallPeriod    = 0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 req_i,
  output logic                                 gnt_o,
  input  logic [AddrWidth-1:0]                 addr_i,
  input  logic                                 we_i,
  input  logic [DataWidth/8-1:0]               be_i,
  input  logic [DataWidth-1:0]                 wdata_i,
  output logic                                 rvalid_o,
  output logic [DataWidth-1:0]                 rdata_o,
  output logic                                 err_o,
  input  logic                                 load_we_i,
  input  logic [$clog2(MemDepthWords)-1:0]     load_addr_i,
  input  logic [DataWidth-1:0]                 load_wdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o
);

  localparam int BytesPerWord = int'(DataWidth / 8);
  localparam int OffBits      = $clog2(BytesPerWord);
  localparam int IdxW         = $clog2(MemDepthWords);
  localparam int CntW         = $clog2(MaxOutstanding + 1);

  typedef struct packed {
    logic                 valid;
    logic [DataWidth-1:0] rdata;
    logic                 err;
  } resp_w_t;

  logic                 stall_now, period_stall, lfsr_stall;
  logic                 accept, in_range;
  logic [IdxW-1:0]      word_idx;
  logic [CntW-1:0]      outstanding_q, outstanding_d;
  resp_w_t              resp_d, resp_q;
  logic [DataWidth-1:0] mem [MemDepthWords];

  // Free-running stall counter; wraps on the stall cycle itself
  if (StallPeriod > 0) begin : g_period
    localparam int SW = ($clog2(StallPeriod) > 0) ? $clog2(StallPeriod) : 1;
    logic [SW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
      if (rst_i)             cnt_q <= '0;
      else if (period_stall) cnt_q <= '0;
      else                   cnt_q <= cnt_q + SW'(1);
    end

    assign period_stall = (cnt_q == SW'(StallPeriod - 1));
  end else begin : g_no_period
    assign period_stall = 1'b0;
  end

`ifdef IBEX_OBI_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= LfsrSeed;
    else       lfsr_q <= (lfsr_q >> 1) ^ ({16{lfsr_q[0]}} & LfsrTaps);
  end

  assign lfsr_stall = (lfsr_q[1:0] == 2'b00);
`else
  assign lfsr_stall = 1'b0;
`endif

  assign stall_now = period_stall | lfsr_stall;
  assign gnt_o     = req_i & ~rst_i & (outstanding_q < CntW'(MaxOutstanding)) & ~stall_now;
  assign accept    = req_i & gnt_o;

  // Byte-offset bits drop out of the index; range check uses wide arithmetic so nothing aliases
  assign in_range = addr_decode(64'(addr_i), 64'(BaseAddr), 64'(MemDepthWords),
                                int'(OffBits));
  assign word_idx = IdxW'((addr_i - BaseAddr) >> OffBits);

  // Backdoor first so enabled bus bytes override it when both hit one word
  always_ff @(posedge clk_i) begin
    if (load_we_i) mem[load_addr_i] <= load_wdata_i;
    if (accept && we_i && in_range) begin
      for (int b = 0; b < BytesPerWord; b++) begin
        if (be_i[b]) mem[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    resp_d       = '0;
    resp_d.valid = accept;
    resp_d.err   = accept & ~in_range;
    if (accept && !we_i && in_range) resp_d.rdata = mem[word_idx];
  end

  ibex_obi_mem_resp_pipe #(
    .Depth   (int'(RespLatency)),
    .entry_t (resp_w_t)
  ) u_resp_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .resp_d (resp_d),
    .resp_q (resp_q)
  );

  assign rvalid_o = resp_q.valid;
  assign rdata_o  = resp_q.rdata;
  assign err_o    = resp_q.err;

  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, rvalid_o})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) outstanding_q <= '0;
    else       outstanding_q <= outstanding_d;
  end

  assign outstanding_o = outstanding_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (accept && !rvalid_o) |-> (outstanding_q < CntW'(MaxOutstanding)));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    rvalid_o |-> (outstanding_q != '0));

endmodule

// File: tb/tb_ibex_obi_mem_responder.sv
// Bench: three responder configs driven side by side against a queue-based reference model.
module tb_ibex_obi_mem_responder;

  localparam int          N     = 3;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 4096;
  // config g: RespLatency / StallPeriod (MaxOutstanding is 2 everywhere)
  localparam logic [N-1:0][7:0] LAT   = {8'd1, 8'd3, 8'd1};
  localparam logic [N-1:0][7:0] STALL = {8'd4, 8'd0, 8'd0};
  localparam int          MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req [N], we [N], gnt [N], rvalid [N], err [N];
  logic [31:0] addr [N], wdata [N], rdata [N];
  logic [3:0]  be [N];
  logic [1:0]  outst [N];
  logic        load_we;
  logic [11:0] load_addr;
  logic [31:0] load_wdata;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    ibex_obi_mem_responder #(
      .RespLatency    (int'(LAT[g])),
      .MaxOutstanding (MAXO),
      .StallPeriod    (int'(STALL[g]))
    ) u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_i         (req[g]),
      .gnt_o         (gnt[g]),
      .addr_i        (addr[g]),
      .we_i          (we[g]),
      .be_i          (be[g]),
      .wdata_i       (wdata[g]),
      .rvalid_o      (rvalid[g]),
      .rdata_o       (rdata[g]),
      .err_o         (err[g]),
      .load_we_i     (load_we),
      .load_addr_i   (load_addr),
      .load_wdata_i  (load_wdata),
      .outstanding_o (outst[g])
    );
  end

  // Reference model: each accepted request becomes a queue entry due LAT cycles later
  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        q [N][$];
  logic [31:0] mm [N][DEPTH];
  logic        acc [N];
  int          cyc, kcnt, checks, errors;
  bit          armed;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc=%0d: got %h want %h", nm, g, cyc, act, exp);
    end
  endtask

  // Called in the low clock phase with this cycle's inputs applied: compare, then advance the model
  task automatic step();
    #1;
    for (int g = 0; g < N; g++) begin
      logic            eg, erv, inr;
      logic [31:0]     rd;
      longint unsigned a;
      int              idx, st;
      exp_t            ent;
      st  = int'(STALL[g]);
      eg  = req[g] && !rst && (q[g].size() < MAXO) && !((st > 0) && ((kcnt % st) == st - 1));
      erv = (q[g].size() > 0) && (q[g][0].due == cyc);
      if (armed) begin
        chk("gnt", g, 32'(gnt[g]), 32'(eg));
        chk("rvalid", g, 32'(rvalid[g]), 32'(erv));
        chk("outstanding", g, 32'(outst[g]), 32'(q[g].size()));
        if (erv) begin
          chk("rdata", g, rdata[g], q[g][0].d);
          chk("err", g, 32'(err[g]), 32'(q[g][0].e));
        end
      end
      acc[g] = eg;
      a   = longint'(addr[g]);
      inr = (a >= longint'(BASE)) && (((a - longint'(BASE)) / 4) < DEPTH);
      idx = inr ? int'((a - longint'(BASE)) / 4) : 0;
      rd  = (eg && inr && !we[g]) ? mm[g][idx] : 32'h0;
      if (erv) void'(q[g].pop_front());
      if (eg) begin
        ent.due = cyc + int'(LAT[g]);
        ent.d   = rd;
        ent.e   = !inr;
        q[g].push_back(ent);
      end
      if (load_we) mm[g][int'(load_addr)] = load_wdata;
      if (eg && we[g] && inr)
        for (int b = 0; b < 4; b++) if (be[g][b]) mm[g][idx][8*b +: 8] = wdata[g][8*b +: 8];
      if (rst) q[g].delete();
    end
    kcnt = rst ? 0 : kcnt + 1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] gen_addr();
    int r;
    r = int'($urandom_range(99));
    if (r < 70) return BASE + 32'(4 * $urandom_range(63)) + 32'($urandom_range(3));
    if (r < 80) return BASE + 32'(4 * 4095) + 32'($urandom_range(3));
    case ($urandom_range(3))
      0:       return 32'h0000_FFFC;
      1:       return BASE + 32'(4 * DEPTH);
      2:       return BASE - 32'd1;
      default: return $urandom | 32'h8000_0000;
    endcase
  endfunction

  initial begin
    logic [4:0] gv5, rv5;
    logic [7:0] gv8;
    int         nacc;
    checks = 0; errors = 0; cyc = 0; kcnt = 0; armed = 1'b0;
    load_we = 1'b0; load_addr = '0; load_wdata = '0;
    for (int g = 0; g < N; g++) begin
      req[g] = 1'b0; we[g] = 1'b0; be[g] = 4'h0; addr[g] = '0; wdata[g] = '0; acc[g] = 1'b0;
    end
    @(negedge clk);
    step();
    armed = 1'b1;

    // Backdoor preload during reset: words 0..63 and the last word
    for (int w = 0; w <= 64; w++) begin
      load_we    = 1'b1;
      load_addr  = (w == 64) ? 12'd4095 : 12'(w);
      load_wdata = (w == 0) ? 32'h0030_2503 : (w == 1) ? 32'h1122_3344 : $urandom;
      step();
    end
    load_we = 1'b0;

    // Reset state, then first read straight out of reset (latency 1)
    req[0] = 1'b1; addr[0] = BASE;
    #1;
    chk("rst_gnt", 0, 32'(gnt[0]), 32'd0);
    chk("rst_rvalid", 0, 32'(rvalid[0]), 32'd0);
    chk("rst_rdata", 0, rdata[0], 32'd0);
    chk("rst_err", 0, 32'(err[0]), 32'd0);
    chk("rst_outst", 0, 32'(outst[0]), 32'd0);
    step();
    rst = 1'b0;
    #1 chk("read_gnt", 0, 32'(gnt[0]), 32'd1);
    step();
    req[0] = 1'b0;
    #1;
    chk("read_rvalid", 0, 32'(rvalid[0]), 32'd1);
    chk("read_rdata", 0, rdata[0], 32'h0030_2503);
    chk("read_err", 0, 32'(err[0]), 32'd0);
    step();

    // Byte-enabled write then immediate read-back
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'b0101; wdata[0] = 32'hDEAD_BEEF; addr[0] = BASE + 32'd4;
    step();
    we[0] = 1'b0;
    step();
    req[0] = 1'b0;
    #1 chk("be_write_rdata", 0, rdata[0], 32'h11AD_33EF);
    step();

    // Out-of-range writes that would alias words 4095 and 0 if truncated
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; wdata[0] = 32'hBAD0_BAD0; addr[0] = 32'h0000_FFFC;
    step();
    addr[0] = BASE + 32'(4 * DEPTH);
    #1;
    chk("oor_lo_err", 0, 32'(err[0]), 32'd1);
    chk("oor_lo_rdata", 0, rdata[0], 32'd0);
    step();
    we[0] = 1'b0; addr[0] = BASE;
    #1;
    chk("oor_hi_err", 0, 32'(err[0]), 32'd1);
    chk("oor_hi_rdata", 0, rdata[0], 32'd0);
    step();
    addr[0] = BASE + 32'(4 * 4095);
    #1 chk("oor_word0_kept", 0, rdata[0], 32'h0030_2503);
    step();
    req[0] = 1'b0;
    step();
    step();

    // Latency 3, two outstanding, request held with consecutive addresses
    do_reset();
    req[1] = 1'b1; nacc = 0;
    for (int i = 0; i < 5; i++) begin
      addr[1] = BASE + 32'(4 * nacc);
      #1;
      gv5[4-i] = gnt[1];
      rv5[4-i] = rvalid[1];
      step();
      if (acc[1]) nacc++;
    end
    chk("lat3_gnt_seq", 1, 32'(gv5), 32'b11001);
    chk("lat3_rvalid_seq", 1, 32'(rv5), 32'b00011);
    req[1] = 1'b0;
    repeat (4) step();

    // StallPeriod 4: grant drops on every 4th cycle only
    do_reset();
    req[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr[2] = BASE + 32'(4 * i);
      #1 gv8[7-i] = gnt[2];
      step();
    end
    chk("stall_gnt_seq", 2, 32'(gv8), 32'b1110_1110);
    req[2] = 1'b0;
    repeat (2) step();

    // Reset with two requests in flight
    do_reset();
    req[1] = 1'b1; addr[1] = BASE;
    step();
    addr[1] = BASE + 32'd4;
    step();
    req[1] = 1'b0; rst = 1'b1;
    #1 chk("midrst_outst_before", 1, 32'(outst[1]), 32'd2);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("midrst_no_rvalid", 1, 32'(rvalid[1]), 32'd0);
      chk("midrst_outst", 1, 32'(outst[1]), 32'd0);
      step();
    end
    req[1] = 1'b1; addr[1] = BASE + 32'd4;
    step();
    req[1] = 1'b0;
    step();
    step();
    #1;
    chk("midrst_mem_rvalid", 1, 32'(rvalid[1]), 32'd1);
    chk("midrst_mem_kept", 1, rdata[1], 32'h1122_3344);
    step();

    // Randomized traffic on all three configs, masters hold each request until granted
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int g = 0; g < N; g++) begin
        if (!req[g] || acc[g]) begin
          if ($urandom_range(99) < 60) begin
            req[g] = 1'b1; addr[g] = gen_addr(); we[g] = 1'($urandom_range(1));
            be[g] = 4'($urandom); wdata[g] = $urandom;
          end else begin
            req[g] = 1'b0;
          end
        end
      end
      load_we    = ($urandom_range(3) == 0);
      load_wdata = $urandom;
      if ($urandom_range(1) == 1 && addr[0] >= BASE && addr[0] < BASE + 32'd256)
        load_addr = 12'((addr[0] - BASE) >> 2);
      else
        load_addr = 12'($urandom_range(63));
      rst = ($urandom_range(499) == 0);
      step();
    end
    for (int g = 0; g < N; g++) req[g] = 1'b0;
    load_we = 1'b0; rst = 1'b0;
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
